// File: rtl/opb_s2p_pkg.sv
// Shared definitions for the fabric-to-PPC snapshot register: register
// offsets, STATUS bit positions, slave FSM state type and STATUS packing.
package opb_s2p_pkg;

    // Byte offsets of the two registers inside the slave window
    localparam logic [31:0] DATA_OFS     = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS   = 32'h0000_0004;

    // Address bit that separates DATA from STATUS; all other offsets alias
    localparam int          WORD_SEL_BIT = 2;

    // STATUS register layout (little-endian value bit numbering)
    localparam int          VALID_BIT    = 0;
    localparam int          OVF_BIT      = 1;
    localparam int          CNT_LSB      = 16;
    localparam int          CNT_FIELD_W  = 16;

    // Write-data bit that requests an overflow clear when the feature is built in
    localparam int          WCLR_BIT     = 1;

    // Slave acknowledge FSM
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } ack_state_e;

    // Assemble the STATUS word; unused bits read as zero
    function automatic logic [31:0] pack_status(
        input logic                   valid,
        input logic                   ovf,
        input logic [CNT_FIELD_W-1:0] cnt
    );
        logic [31:0] s;
        s                          = '0;
        s[CNT_LSB +: CNT_FIELD_W]  = cnt;
        s[OVF_BIT]                 = ovf;
        s[VALID_BIT]               = valid;
        return s;
    endfunction

endpackage

// File: rtl/opb_s2p_if.sv
// OPB slave bus bundle for the snapshot register. Vectors keep the OPB
// big-endian bit numbering ([0:31], bit 0 = MSB); numeric values are unchanged
// when assigned to little-endian vectors.
interface opb_s2p_if;

    // Master-driven request signals
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;

    // Slave-driven response signals
    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

endinterface

// File: rtl/opb_slave_ack_fsm.sv
// Generic single-beat OPB slave front end: window decode, IDLE/ACK FSM and
// one-cycle xferAck. Transfer attributes (direction, word select) are latched
// on the hit so the owner can act on them during the ACK cycle.
module opb_slave_ack_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h010B_2700,
    parameter logic [31:0] C_HIGHADDR = 32'h010B_27FF
)(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        select_i,
    input  logic        rnw_i,
    input  logic [31:0] abus_i,
    output logic        start_o,
    output logic        ack_o,
    output logic        rnw_o,
    output logic        word_sel_o
);

    ack_state_e state_q;
    logic       ack_q;
    logic       rnw_q;
    logic       word_sel_q;
    logic       in_window;

    assign in_window = (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);

    // A transfer starts only from IDLE; select is ignored while acknowledging
    assign start_o = select_i && in_window && (state_q == S_IDLE);

    // IDLE -> ACK on a hit, ACK -> IDLE unconditionally; ack is registered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            rnw_q      <= 1'b0;
            word_sel_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_o) begin
                        state_q    <= S_ACK;
                        ack_q      <= 1'b1;
                        rnw_q      <= rnw_i;
                        word_sel_q <= abus_i[WORD_SEL_BIT];
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign rnw_o      = rnw_q;
    assign word_sel_o = word_sel_q;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PPC snapshot register. Fabric pushes 32-bit words with
// user_valid; the PowerPC reads DATA (clears valid) and STATUS (valid,
// sticky overflow, saturating overflow count) over OPB.
// Optional feature macro: OPB_S2P_WRITE_CLEAR_EN -- when defined, writing
// STATUS with bit 1 set clears the overflow flag and counter.
module opb_register_simulink2ppc_snap
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B_2700,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B_27FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          C_OVF_CNT_W  = 16
)(
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    opb_s2p_if.slave    opb,
    input  logic [31:0] user_data_in,
    input  logic        user_valid
);

    // Bus widths and family are fixed for this slave; kept for tool-flow compatibility
    localparam bit unused_cfg = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) &&
                                (C_FAMILY == "virtex5");

    localparam logic DATA_SEL   = DATA_OFS[WORD_SEL_BIT];
    localparam logic STATUS_SEL = STATUS_OFS[WORD_SEL_BIT];
    localparam logic [C_OVF_CNT_W-1:0] CNT_ONE = (C_OVF_CNT_W)'(1);

    // Overflow counter increments but sticks at all-ones
    function automatic logic [C_OVF_CNT_W-1:0] sat_inc(input logic [C_OVF_CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [31:0]            addr_w;
    logic                   start;
    logic                   ack;
    logic                   xfer_rnw;
    logic                   xfer_sel;

    logic [31:0]            holding_q, holding_d;
    logic                   valid_q, valid_d;
    logic                   ovf_sticky_q, ovf_sticky_d;
    logic [C_OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [31:0]            dbus_q, dbus_d;

    logic [31:0]            status_w;
    logic                   clr_rd;
    logic                   ovf_evt;
    logic                   wr_clr;
    logic                   unused_bus;

    // Byte enables, sequential hint and (when unused) write data do not affect this slave
    assign unused_bus = ^{opb.OPB_BE, opb.OPB_seqAddr, opb.OPB_DBus, unused_cfg};

    assign addr_w = opb.OPB_ABus;

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .clk_i      (OPB_Clk),
        .rst_ni     (OPB_Rst_n),
        .select_i   (opb.OPB_select),
        .rnw_i      (opb.OPB_RNW),
        .abus_i     (addr_w),
        .start_o    (start),
        .ack_o      (ack),
        .rnw_o      (xfer_rnw),
        .word_sel_o (xfer_sel)
    );

    assign status_w = pack_status(valid_q, ovf_sticky_q, CNT_FIELD_W'(ovf_cnt_q));

    // Read data is captured in the hit cycle so the ACK cycle presents it;
    // every other cycle drives zero so the shared OR-bus is not disturbed
    assign dbus_d = (start && opb.OPB_RNW)
                  ? ((addr_w[WORD_SEL_BIT] == STATUS_SEL) ? status_w : holding_q)
                  : '0;

    // A DATA read consumes the word on its ACK cycle
    assign clr_rd  = ack && xfer_rnw && (xfer_sel == DATA_SEL);

    // Overwriting an unread word is an overflow unless the read is consuming it now
    assign ovf_evt = user_valid && valid_q && !clr_rd;

`ifdef OPB_S2P_WRITE_CLEAR_EN
    logic wclr_req_q;

    // Latch the clear request with the hit so it is independent of bus hold time
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            wclr_req_q <= 1'b0;
        end else begin
            wclr_req_q <= start && !opb.OPB_RNW &&
                          (addr_w[WORD_SEL_BIT] == STATUS_SEL) &&
                          opb.OPB_DBus[31-WCLR_BIT];
        end
    end

    assign wr_clr = ack && wclr_req_q;
`else
    assign wr_clr = 1'b0;
`endif

    // Next-state of the holding register and status fields
    always_comb begin
        holding_d    = holding_q;
        valid_d      = valid_q;
        ovf_sticky_d = ovf_sticky_q;
        ovf_cnt_d    = ovf_cnt_q;

        if (user_valid) begin
            holding_d = user_data_in;
            valid_d   = 1'b1;
        end else if (clr_rd) begin
            valid_d   = 1'b0;
        end

        if (ovf_evt) begin
            ovf_sticky_d = 1'b1;
            ovf_cnt_d    = wr_clr ? CNT_ONE : sat_inc(ovf_cnt_q);
        end else if (wr_clr) begin
            ovf_sticky_d = 1'b0;
            ovf_cnt_d    = '0;
        end
    end

    // State and read-data registers, all cleared by the asynchronous reset
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            holding_q    <= '0;
            valid_q      <= 1'b0;
            ovf_sticky_q <= 1'b0;
            ovf_cnt_q    <= '0;
            dbus_q       <= '0;
        end else begin
            holding_q    <= holding_d;
            valid_q      <= valid_d;
            ovf_sticky_q <= ovf_sticky_d;
            ovf_cnt_q    <= ovf_cnt_d;
            dbus_q       <= dbus_d;
        end
    end

    assign opb.Sl_DBus    = dbus_q;
    assign opb.Sl_xferAck = ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed bench for the snapshot register, built with a 2-bit overflow
// counter so saturation is reachable. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] A_DATA   = 32'h010B_2700;
    localparam logic [31:0] A_STATUS = 32'h010B_2704;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst_n;
    logic [31:0] user_data_in;
    logic        user_valid;

    int vectors     = 0;
    int miscompares = 0;

    opb_s2p_if bus();

    opb_register_simulink2ppc_snap #(
        .C_OVF_CNT_W (2)
    ) dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst_n    (OPB_Rst_n),
        .opb          (bus),
        .user_data_in (user_data_in),
        .user_valid   (user_valid)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One OPB transfer starting at a falling edge; checks latency, data and idle bus around it
    task automatic xfer(input logic rnw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] expv, input string tag);
        int          lat;
        logic [31:0] d;
        check({tag, "_pre_dbus"}, bus.Sl_DBus, 32'h0);
        bus.OPB_ABus   = a;
        bus.OPB_RNW    = rnw;
        bus.OPB_DBus   = wd;
        bus.OPB_select = 1'b1;
        lat = 0;
        d   = 32'hFFFF_FFFF;
        while (lat < 8) begin
            @(negedge OPB_Clk);
            lat++;
            if (bus.Sl_xferAck) begin
                d = bus.Sl_DBus;
                break;
            end
        end
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_ABus   = '0;
        bus.OPB_DBus   = '0;
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_data"}, d, expv);
        @(negedge OPB_Clk);
        check({tag, "_post_ack"}, 32'(bus.Sl_xferAck), 32'd0);
        check({tag, "_post_dbus"}, bus.Sl_DBus, 32'h0);
    endtask

    task automatic push(input logic [31:0] w);
        user_data_in = w;
        user_valid   = 1'b1;
        @(negedge OPB_Clk);
        user_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] bad_addr [2];
        int          acks;
        logic [31:0] dor;

        bus.OPB_ABus    = '0;
        bus.OPB_BE      = 4'hF;
        bus.OPB_DBus    = '0;
        bus.OPB_RNW     = 1'b0;
        bus.OPB_select  = 1'b0;
        bus.OPB_seqAddr = 1'b0;
        user_data_in    = '0;
        user_valid      = 1'b0;
        OPB_Rst_n       = 1'b0;

        // Reset values
        repeat (3) @(negedge OPB_Clk);
        check("rst_dbus", bus.Sl_DBus, 32'h0);
        check("rst_ack", 32'(bus.Sl_xferAck), 32'd0);
        check("tied_zero", 32'({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}), 32'd0);
        OPB_Rst_n = 1'b1;
        @(negedge OPB_Clk);
        xfer(1'b1, A_STATUS, 32'h0, 32'h0000_0000, "rst_status");
        xfer(1'b1, A_DATA,   32'h0, 32'h0000_0000, "rst_data");

        // Single capture then read; the read clears valid
        push(32'hDEAD_BEEF);
        xfer(1'b1, A_DATA,   32'h0, 32'hDEAD_BEEF, "cap_data");
        xfer(1'b1, A_STATUS, 32'h0, 32'h0000_0000, "cap_status");

        // DATA read ACK coincides with a new capture
        push(32'h0000_0044);
        check("coin_pre_dbus", bus.Sl_DBus, 32'h0);
        bus.OPB_ABus   = A_DATA;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b1;
        @(negedge OPB_Clk);
        check("coin_ack", 32'(bus.Sl_xferAck), 32'd1);
        check("coin_data", bus.Sl_DBus, 32'h0000_0044);
        user_data_in   = 32'h0000_0055;
        user_valid     = 1'b1;
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_ABus   = '0;
        @(negedge OPB_Clk);
        user_valid     = 1'b0;
        check("coin_post_ack", 32'(bus.Sl_xferAck), 32'd0);
        xfer(1'b1, A_STATUS, 32'h0, 32'h0000_0001, "coin_status");
        xfer(1'b1, A_DATA,   32'h0, 32'h0000_0055, "coin_new");
        xfer(1'b1, A_STATUS, 32'h0, 32'h0000_0000, "coin_status2");

        // Back-to-back captures without a read: two overflows
        push(32'h1);
        push(32'h2);
        push(32'h3);
        xfer(1'b1, A_STATUS, 32'h0, 32'h0002_0003, "ovf_status");
        xfer(1'b1, A_DATA,   32'h0, 32'h0000_0003, "ovf_data");
        xfer(1'b1, A_STATUS, 32'h0, 32'h0002_0002, "ovf_status2");

        // Addresses just outside the window never acknowledge
        bad_addr[0] = 32'h010B_2800;
        bad_addr[1] = 32'h010B_26FC;
        for (int i = 0; i < 2; i++) begin
            bus.OPB_ABus   = bad_addr[i];
            bus.OPB_RNW    = 1'b1;
            bus.OPB_select = 1'b1;
            acks = 0;
            dor  = '0;
            repeat (8) begin
                @(negedge OPB_Clk);
                if (bus.Sl_xferAck) acks++;
                dor |= bus.Sl_DBus;
            end
            bus.OPB_select = 1'b0;
            bus.OPB_RNW    = 1'b0;
            bus.OPB_ABus   = '0;
            check("miss_acks", 32'(acks), 32'd0);
            check("miss_dbus", dor, 32'h0);
            @(negedge OPB_Clk);
        end

        // Counter saturates at 3 with a 2-bit width
        push(32'h7);
        push(32'h8);
        push(32'h9);
        xfer(1'b1, A_STATUS, 32'h0, 32'h0003_0003, "sat_status");
        push(32'hA);
        push(32'hB);
        xfer(1'b1, A_STATUS, 32'h0, 32'h0003_0003, "sat_hold");

`ifdef OPB_S2P_WRITE_CLEAR_EN
        // Write-clear of the overflow state, then overflow beating a clear
        xfer(1'b0, A_STATUS, 32'h0000_0001, 32'h0, "wnoclr");
        xfer(1'b1, A_STATUS, 32'h0, 32'h0003_0003, "wnoclr_status");
        xfer(1'b0, A_STATUS, 32'h0000_0002, 32'h0, "wclr");
        xfer(1'b1, A_STATUS, 32'h0, 32'h0000_0001, "wclr_status");
        push(32'hC);
        push(32'hE);
        xfer(1'b1, A_STATUS, 32'h0, 32'h0002_0003, "wclr_reovf");
        bus.OPB_ABus   = A_STATUS;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_DBus   = 32'h0000_0002;
        bus.OPB_select = 1'b1;
        @(negedge OPB_Clk);
        check("wclr_coin_ack", 32'(bus.Sl_xferAck), 32'd1);
        user_data_in   = 32'h0000_000F;
        user_valid     = 1'b1;
        bus.OPB_select = 1'b0;
        bus.OPB_DBus   = '0;
        bus.OPB_ABus   = '0;
        @(negedge OPB_Clk);
        user_valid     = 1'b0;
        xfer(1'b1, A_STATUS, 32'h0, 32'h0001_0003, "wclr_coin_status");
        xfer(1'b1, A_DATA,   32'h0, 32'h0000_000F, "wclr_coin_data");
`else
        // Writes are acknowledged but change nothing
        xfer(1'b0, A_STATUS, 32'h0000_0002, 32'h0, "wr_status");
        xfer(1'b1, A_STATUS, 32'h0, 32'h0003_0003, "wr_status_chk");
        xfer(1'b0, A_DATA,   32'h1234_5678, 32'h0, "wr_data");
        xfer(1'b1, A_DATA,   32'h0, 32'h0000_000B, "wr_data_chk");
`endif

        // Reset asserted between the hit and its ACK: no ack, state cleared
        bus.OPB_ABus   = A_STATUS;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b1;
        #2;
        OPB_Rst_n = 1'b0;
        @(negedge OPB_Clk);
        check("rstmid_ack", 32'(bus.Sl_xferAck), 32'd0);
        check("rstmid_dbus", bus.Sl_DBus, 32'h0);
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_ABus   = '0;
        @(negedge OPB_Clk);
        OPB_Rst_n = 1'b1;
        @(negedge OPB_Clk);
        xfer(1'b1, A_STATUS, 32'h0, 32'h0000_0000, "rstmid_status");
        xfer(1'b1, A_DATA,   32'h0, 32'h0000_0000, "rstmid_data");

        // Reset asserted while the ack is showing drops it at once
        push(32'h0000_0077);
        bus.OPB_ABus   = A_DATA;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b1;
        @(negedge OPB_Clk);
        check("rstack_ack_on", 32'(bus.Sl_xferAck), 32'd1);
        check("rstack_data", bus.Sl_DBus, 32'h0000_0077);
        #1;
        OPB_Rst_n = 1'b0;
        #1;
        check("rstack_ack_off", 32'(bus.Sl_xferAck), 32'd0);
        check("rstack_dbus", bus.Sl_DBus, 32'h0);
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_ABus   = '0;
        @(negedge OPB_Clk);
        OPB_Rst_n = 1'b1;
        @(negedge OPB_Clk);
        xfer(1'b1, A_STATUS, 32'h0, 32'h0000_0000, "rstack_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
